// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, store-width codes
// and default sizing constants.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  // Store-width codes as used by the cache write path
  localparam logic [2:0] SW_BYTE = 3'b101;
  localparam logic [2:0] SW_HALF = 3'b110;
  localparam logic [2:0] SW_WORD = 3'b111;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_LATENCY    = 1;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and registered read data.
// Contents are deliberately left unreset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder behind the cache miss/writeback path.
// Optional address checking is enabled with the DMEM_ERR_CHECK_EN macro.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic        mem_resp_valid,
  output logic [31:0] mem_rdata
`ifdef DMEM_ERR_CHECK_EN
  ,
  output logic        mem_err
`endif
);

  dmem_state_t state, state_next;
  logic [3:0]            wait_cnt;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  err_q;
  logic                  req_err;
  logic                  accept;
  logic                  issue;
  logic [31:0]           array_rdata;

  assign accept = mem_req && (state == IDLE);
  // Reset on the issuing edge must still suppress the array operation
  assign issue  = (state == ACCESS) && (wait_cnt == 4'd0) && !rst;

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (|mem_addr[31:ADDR_WIDTH+2]) || (|mem_addr[1:0]);
`else
  logic [31-ADDR_WIDTH:0] unused_addr_bits;
  assign unused_addr_bits = {mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (accept) wait_cnt <= 4'(LATENCY - 1);
      else if (state == ACCESS && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      wr_q    <= mem_wr;
      addr_q  <= mem_addr[ADDR_WIDTH+1:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      err_q   <= req_err;
    end
  end

  always_comb begin
    state_next     = state;
    mem_ready      = 1'b0;
    mem_resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (mem_req) state_next = ACCESS;
      end
      ACCESS: if (wait_cnt == 4'd0) state_next = RESP;
      RESP: begin
        mem_resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (issue && !err_q),
    .we    (wr_q ? wstrb_q : 4'b0000),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  assign mem_rdata = (state == RESP && !wr_q && !err_q) ? array_rdata : 32'd0;

`ifdef DMEM_ERR_CHECK_EN
  assign mem_err = (state == RESP) && err_q;
`endif

endmodule
